// File: rtl/uart_dbg_bridge.sv
// UART debug bridge: byte command protocol to bus read/write and core halt/run/reset control.
// Optional burst-write command 0x06 is built when DBG_BRIDGE_BURST_EN is defined.
module uart_dbg_bridge #(
  parameter int CLK_HZ      = 48_000_000,
  parameter int BAUD        = 115_200,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RST_CYC     = 16,
  parameter int TIMEOUT_CYC = 1 << 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              tx,
  output logic              cpu_clk_en,
  output logic              cpu_rst,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam int RST_W = $clog2(RST_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC);

  localparam logic [CNT_W-1:0] DIV_FULL = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] DIV_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [RST_W-1:0] RST_FULL = RST_W'(RST_CYC - 1);
  localparam logic [TO_W-1:0]  TO_FULL  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       AB_M1    = 8'(ADDR_W / 8 - 1);
  localparam logic [7:0]       DB       = 8'(DATA_W / 8);
  localparam logic [7:0]       DB_M1    = 8'(DATA_W / 8 - 1);

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_HALT  = 8'h03;
  localparam logic [7:0] CMD_RUN   = 8'h04;
  localparam logic [7:0] CMD_RESET = 8'h05;
  localparam logic [7:0] REPLY_ACK = 8'h06;
  localparam logic [7:0] REPLY_NAK = 8'h15;
`ifdef DBG_BRIDGE_BURST_EN
  localparam logic [7:0] CMD_BURST = 8'h06;
  localparam logic [7:0] AB        = 8'(ADDR_W / 8);
`endif

  function automatic logic [ADDR_W-1:0] push_addr(input logic [ADDR_W-1:0] v, input logic [7:0] b);
    logic [ADDR_W+7:0] t;
    t = {b, v};
    return t[ADDR_W+7:8];
  endfunction

  function automatic logic [DATA_W-1:0] push_data(input logic [DATA_W-1:0] v, input logic [7:0] b);
    logic [DATA_W+7:0] t;
    t = {b, v};
    return t[DATA_W+7:8];
  endfunction

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        rx_st;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_sh;
  logic             rx_q1, rx_s, rx_prev;
  logic             rx_valid, rx_ferr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q1    <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      rx_st    <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_q1    <= rx;
      rx_s     <= rx_q1;
      rx_prev  <= rx_s;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_st)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_cnt <= DIV_HALF;
            rx_st  <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (!rx_s) begin
              rx_cnt <= DIV_FULL;
              rx_bit <= '0;
              rx_st  <= RX_DATA;
            end else begin
              rx_st <= RX_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_sh  <= {rx_s, rx_sh[7:1]};
            rx_cnt <= DIV_FULL;
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) begin
            rx_valid <= rx_s;
            rx_ferr  <= !rx_s;
            rx_st    <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // ---------------- transmitter: sends tx_n bytes of tx_data back-to-back ----------------
  logic              tx_load;
  logic [DATA_W-1:0] tx_data;
  logic [7:0]        tx_n;
  logic [DATA_W-1:0] tx_buf;
  logic [8:0]        tx_sh;
  logic [3:0]        tx_bit;
  logic [CNT_W-1:0]  tx_cnt;
  logic [7:0]        tx_left;
  logic              tx_active, tx_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx        <= 1'b1;
      tx_buf    <= '0;
      tx_sh     <= '1;
      tx_bit    <= '0;
      tx_cnt    <= '0;
      tx_left   <= '0;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_load) begin
        tx_buf    <= tx_data >> 8;
        tx_sh     <= {1'b1, tx_data[7:0]};
        tx_left   <= tx_n;
        tx        <= 1'b0;
        tx_bit    <= 4'd9;
        tx_cnt    <= DIV_FULL;
        tx_active <= 1'b1;
      end else if (tx_active) begin
        if (tx_cnt == '0) begin
          tx_cnt <= DIV_FULL;
          if (tx_bit == 4'd0) begin
            if (tx_left > 8'd1) begin
              tx_buf  <= tx_buf >> 8;
              tx_sh   <= {1'b1, tx_buf[7:0]};
              tx_left <= tx_left - 8'd1;
              tx      <= 1'b0;
              tx_bit  <= 4'd9;
            end else begin
              tx_active <= 1'b0;
              tx_done   <= 1'b1;
            end
          end else begin
            tx     <= tx_sh[0];
            tx_sh  <= {1'b1, tx_sh[8:1]};
            tx_bit <= tx_bit - 4'd1;
          end
        end else begin
          tx_cnt <= tx_cnt - 1'b1;
        end
      end
    end
  end

  // ---------------- command parser ----------------
  // state | meaning
  // IDLE  | waiting for a command byte
  // ADDR  | collecting little-endian address bytes (and burst count)
  // DATA  | collecting little-endian write data bytes
  // BUS   | bus_req held until bus_ack
  // RSTP  | core reset pulse running
  // RESP  | reply bytes being transmitted
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RSTP, S_RESP} state_t;

  state_t           state;
  logic [7:0]       cmd;
  logic [7:0]       idx;
  logic [TO_W-1:0]  to_cnt;
  logic [RST_W-1:0] rst_cnt;
  logic             saved_en;
`ifdef DBG_BRIDGE_BURST_EN
  logic [8:0]       burst_left;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cmd        <= '0;
      idx        <= '0;
      to_cnt     <= '0;
      rst_cnt    <= '0;
      saved_en   <= 1'b0;
      tx_load    <= 1'b0;
      tx_data    <= '0;
      tx_n       <= '0;
      cpu_clk_en <= 1'b0;
      cpu_rst    <= 1'b1;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
`ifdef DBG_BRIDGE_BURST_EN
      burst_left <= '0;
`endif
    end else begin
      tx_load <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            cmd    <= rx_sh;
            idx    <= '0;
            to_cnt <= TO_FULL;
            tx_n   <= 8'd1;
            case (rx_sh)
              CMD_WRITE, CMD_READ: state <= S_ADDR;
`ifdef DBG_BRIDGE_BURST_EN
              CMD_BURST: state <= S_ADDR;
`endif
              CMD_HALT: begin
                cpu_clk_en <= 1'b0;
                tx_data    <= DATA_W'(REPLY_ACK);
                tx_load    <= 1'b1;
                state      <= S_RESP;
              end
              CMD_RUN: begin
                cpu_rst    <= 1'b0;
                cpu_clk_en <= 1'b1;
                tx_data    <= DATA_W'(REPLY_ACK);
                tx_load    <= 1'b1;
                state      <= S_RESP;
              end
              CMD_RESET: begin
                saved_en   <= cpu_clk_en;
                cpu_rst    <= 1'b1;
                cpu_clk_en <= 1'b1;
                rst_cnt    <= RST_FULL;
                state      <= S_RSTP;
              end
              default: begin
                tx_data <= DATA_W'(REPLY_NAK);
                tx_load <= 1'b1;
                state   <= S_RESP;
              end
            endcase
          end
        end
        S_ADDR: begin
          if (rx_ferr) begin
            state <= S_IDLE;
          end else if (rx_valid) begin
            to_cnt <= TO_FULL;
`ifdef DBG_BRIDGE_BURST_EN
            if (cmd == CMD_BURST && idx == AB) begin
              burst_left <= {rx_sh == 8'd0, rx_sh};
              idx        <= '0;
              state      <= S_DATA;
            end else
`endif
            begin
              bus_addr <= push_addr(bus_addr, rx_sh);
              if (idx == AB_M1) begin
                idx <= '0;
                case (cmd)
                  CMD_READ: begin
                    bus_req <= 1'b1;
                    bus_we  <= 1'b0;
                    state   <= S_BUS;
                  end
`ifdef DBG_BRIDGE_BURST_EN
                  CMD_BURST: idx <= idx + 8'd1;  // count byte follows the address
`endif
                  default: state <= S_DATA;
                endcase
              end else begin
                idx <= idx + 8'd1;
              end
            end
          end else if (to_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (rx_ferr) begin
            state <= S_IDLE;
          end else if (rx_valid) begin
            to_cnt    <= TO_FULL;
            bus_wdata <= push_data(bus_wdata, rx_sh);
            if (idx == DB_M1) begin
              idx     <= '0;
              bus_req <= 1'b1;
              bus_we  <= 1'b1;
              state   <= S_BUS;
            end else begin
              idx <= idx + 8'd1;
            end
          end else if (to_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
        S_BUS: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
`ifdef DBG_BRIDGE_BURST_EN
            if (cmd == CMD_BURST) begin
              bus_addr   <= bus_addr + ADDR_W'(DATA_W / 8);
              burst_left <= burst_left - 9'd1;
              if (burst_left == 9'd1) begin
                tx_data <= DATA_W'(REPLY_ACK);
                tx_n    <= 8'd1;
                tx_load <= 1'b1;
                state   <= S_RESP;
              end else begin
                to_cnt <= TO_FULL;
                state  <= S_DATA;
              end
            end else
`endif
            if (cmd == CMD_READ) begin
              tx_data <= bus_rdata;
              tx_n    <= DB;
              tx_load <= 1'b1;
              state   <= S_RESP;
            end else begin
              tx_data <= DATA_W'(REPLY_ACK);
              tx_n    <= 8'd1;
              tx_load <= 1'b1;
              state   <= S_RESP;
            end
          end
        end
        S_RSTP: begin
          if (rst_cnt == '0) begin
            cpu_rst    <= 1'b0;
            cpu_clk_en <= saved_en;
            tx_data    <= DATA_W'(REPLY_ACK);
            tx_n       <= 8'd1;
            tx_load    <= 1'b1;
            state      <= S_RESP;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (tx_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Directed bench for uart_dbg_bridge at DIV = 10; burst test follows DBG_BRIDGE_BURST_EN.
module tb_uart_dbg_bridge;
  localparam int DIV     = 10;
  localparam int TIMEOUT = 500;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx = 1'b1;
  logic        tx, cpu_clk_en, cpu_rst, bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0]  tx_q[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          n_reads = 0;
  logic [31:0] rd_addr = '0;
  logic        last_we = 1'b0;
  int          ack_dly = 3;
  logic        ack_en = 1'b1;
  logic [31:0] rdata_val = '0;
  int          hi_cnt = 0;
  logic        hi_en_bad = 1'b0;
  int          pulse_len = 0;
  logic        pulse_en_ok = 1'b0;

  uart_dbg_bridge #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .ADDR_W(32), .DATA_W(32),
    .RST_CYC(16), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx),
    .cpu_clk_en(cpu_clk_en), .cpu_rst(cpu_rst),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic expect_reply(input string tag, input logic [7:0] exp);
    logic [15:0] got;
    got = 16'hDEAD;
    for (int i = 0; i < 600; i++) begin
      if (tx_q.size() != 0) break;
      @(negedge clk);
    end
    if (tx_q.size() != 0) got = {8'h00, tx_q.pop_front()};
    chk(tag, 64'(got), 64'({8'h00, exp}));
  endtask

  // serial line decoder for replies
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx);
      repeat (DIV / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(posedge clk);
        #1 b[i] = tx;
      end
      repeat (DIV) @(posedge clk);
      #1 chk("tx_stop_bit", 64'(tx), 64'(1));
      tx_q.push_back(b);
    end
  end

  // bus slave
  initial begin
    logic [31:0] a;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus_req && ack_en) begin
        a = bus_addr;
        last_we = bus_we;
        if (bus_we) begin
          wr_addr.push_back(bus_addr);
          wr_data.push_back(bus_wdata);
        end else begin
          n_reads++;
          rd_addr = bus_addr;
        end
        for (int i = 0; i < ack_dly; i++) begin
          @(posedge clk); #1;
          chk("bus_stable", 64'({bus_req, bus_addr}), 64'({1'b1, a}));
        end
        bus_rdata = rdata_val;
        bus_ack   = 1'b1;
        @(posedge clk); #1;
        bus_ack = 1'b0;
      end
    end
  end

  // core reset pulse width monitor
  initial begin
    forever begin
      @(posedge clk); #1;
      if (cpu_rst === 1'b1) begin
        hi_cnt++;
        if (cpu_clk_en !== 1'b1) hi_en_bad = 1'b1;
      end else if (hi_cnt != 0) begin
        pulse_len   = hi_cnt;
        pulse_en_ok = !hi_en_bad;
        hi_cnt      = 0;
        hi_en_bad   = 1'b0;
      end
    end
  end

  initial begin
    int n0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #20;
    chk("rst_tx", 64'(tx), 64'(1));
    chk("rst_cpu_rst", 64'(cpu_rst), 64'(1));
    chk("rst_clk_en", 64'(cpu_clk_en), 64'(0));
    chk("rst_bus_req", 64'({bus_req, bus_we, bus_addr, bus_wdata[30:0]}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_cpu", 64'({tx, cpu_rst, cpu_clk_en}), 64'(3'b110));

    // run
    send_byte(8'h04);
    expect_reply("run_ack", 8'h06);
    chk("run_cpu", 64'({cpu_rst, cpu_clk_en}), 64'(2'b01));

    // write
    ack_dly = 3;
    send_byte(8'h01);
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    expect_reply("wr_ack", 8'h06);
    chk("wr_count", 64'(wr_addr.size()), 64'(1));
    chk("wr_addr", 64'(wr_addr[0]), 64'h10);
    chk("wr_data", 64'(wr_data[0]), 64'hDEADBEEF);

    // read
    ack_dly = 1;
    rdata_val = 32'h12345678;
    send_byte(8'h02);
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    expect_reply("rd_b0", 8'h78);
    expect_reply("rd_b1", 8'h56);
    expect_reply("rd_b2", 8'h34);
    expect_reply("rd_b3", 8'h12);
    chk("rd_we", 64'(last_we), 64'(0));
    chk("rd_addr", 64'(rd_addr), 64'h10);
    chk("rd_count", 64'(n_reads), 64'(1));

    // halt, then reset pulse while halted
    send_byte(8'h03);
    expect_reply("halt_ack", 8'h06);
    chk("halt_en", 64'(cpu_clk_en), 64'(0));
    send_byte(8'h05);
    expect_reply("rstp_ack", 8'h06);
    chk("rstp_len", 64'(pulse_len), 64'(16));
    chk("rstp_en_forced", 64'(pulse_en_ok), 64'(1));
    chk("rstp_after", 64'({cpu_rst, cpu_clk_en}), 64'(2'b00));

    // unknown command
    send_byte(8'h7F);
    expect_reply("nak_7f", 8'h15);

    // framing error: a run command with a bad stop bit must be dropped
    send_byte(8'h04, 1'b0);
    repeat (200) @(negedge clk);
    chk("ferr_no_reply", 64'(tx_q.size()), 64'(0));
    chk("ferr_en", 64'(cpu_clk_en), 64'(0));
    chk("ferr_no_bus", 64'(wr_addr.size() + n_reads), 64'(2));

    // timeout mid-address, then a clean read
    send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
    repeat (TIMEOUT + 200) @(negedge clk);
    chk("to_no_reply", 64'(tx_q.size()), 64'(0));
    chk("to_no_write", 64'(wr_addr.size()), 64'(1));
    rdata_val = 32'hCAFEF00D;
    send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    expect_reply("to_rd_b0", 8'h0D);
    expect_reply("to_rd_b1", 8'hF0);
    expect_reply("to_rd_b2", 8'hFE);
    expect_reply("to_rd_b3", 8'hCA);
    chk("to_rd_addr", 64'(rd_addr), 64'h20);

`ifdef DBG_BRIDGE_BURST_EN
    ack_dly = 0;
    n0 = wr_addr.size();
    send_byte(8'h06);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    expect_reply("burst_ack", 8'h06);
    repeat (150) @(negedge clk);
    chk("burst_single_reply", 64'(tx_q.size()), 64'(0));
    chk("burst_count", 64'(wr_addr.size() - n0), 64'(2));
    if (wr_addr.size() >= n0 + 2) begin
      chk("burst_a0", 64'(wr_addr[n0]), 64'h100);
      chk("burst_d0", 64'(wr_data[n0]), 64'h44332211);
      chk("burst_a1", 64'(wr_addr[n0+1]), 64'h104);
      chk("burst_d1", 64'(wr_data[n0+1]), 64'h88776655);
    end
`else
    n0 = wr_addr.size();
    send_byte(8'h06);
    expect_reply("nak_06", 8'h15);
    chk("nak_06_no_write", 64'(wr_addr.size()), 64'(n0));
`endif

    // stalled bus then asynchronous reset
    ack_en = 1'b0;
    send_byte(8'h02);
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 50; i++) begin
      if (bus_req) break;
      @(negedge clk);
    end
    chk("stall_req", 64'({bus_req, bus_we, bus_addr}), 64'({2'b10, 32'h40}));
    repeat (40) @(negedge clk);
    chk("stall_hold", 64'(bus_req), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bus", 64'({bus_req, bus_addr}), 64'(0));
    chk("arst_cpu", 64'({tx, cpu_rst, cpu_clk_en}), 64'(3'b110));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
